mux_gamma_scheduler: RTL and testbench

- Time-multiplexes one shared column between NNET spike networks, one gamma wave per grant.
- Arbitrates the networks' wave requests round-robin.
- Routes the granted network's P-bit input volley to the column and drives the column's gamma reset (grst) at wave boundaries.
- Demultiplexes the column's Q output spikes into per-network result registers with a valid pulse.
- Sits between the replay buffers / network inputs and the column instance in the multiplexed column.

---
 rtl/mux_gamma_scheduler_pkg.sv | 35 +++
 rtl/mux_gamma_scheduler_if.sv | 42 ++++
 rtl/mux_gamma_scheduler_rr_arbiter.sv | 32 +++
 rtl/mux_gamma_scheduler.sv | 147 ++++++++++++++
 tb/tb_mux_gamma_scheduler.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/mux_gamma_scheduler_pkg.sv
// Shared types and the round-robin pick helper for the gamma-wave column multiplexer.
// rr_pick handles up to RR_MAX requesters, so any NNET in 2..8 can share it.
package mux_sched_pkg;

  localparam int unsigned NNET_DEF      = 2;
  localparam int unsigned GAMMA_LEN_DEF = 8;
  localparam int unsigned RR_MAX        = 8;
  localparam int unsigned RR_IW         = 3;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} sched_state_t;

  typedef struct packed {
    logic             found;
    logic [RR_IW-1:0] idx;
  } rr_pick_t;

  // First set request at or after ptr, wrapping modulo n (ptr must be < n).
  function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0] req,
                                       input logic [RR_IW-1:0]  ptr,
                                       input int unsigned       n);
    rr_pick_t    r;
    int unsigned j;
    r = '0;
    for (int unsigned i = 0; i < RR_MAX; i++) begin
      j = 32'(ptr) + i;
      if (j >= n) j = j - n;
      if (i < n && !r.found && req[j[RR_IW-1:0]]) begin
        r.found = 1'b1;
        r.idx   = j[RR_IW-1:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_gamma_scheduler_if.sv
// Request/grant, column and result bundle of the gamma-wave scheduler; master = scheduler side.
// The out_time bus exists only when MUX_SPIKE_TIME_EN is defined.
interface mux_gamma_scheduler_if #(
  parameter int P    = 64,
  parameter int Q    = 2,
  parameter int NNET = 2
`ifdef MUX_SPIKE_TIME_EN
  ,
  parameter int CW   = 3
`endif
);

  logic [NNET-1:0]   req;
  logic [NNET-1:0]   ack;
  logic [NNET*P-1:0] data_in;
  logic [P-1:0]      col_data;
  logic              col_grst;
  logic [Q-1:0]      col_spikes;
  logic [NNET*Q-1:0] out_spikes;
  logic [NNET-1:0]   out_valid;
  logic              busy;
`ifdef MUX_SPIKE_TIME_EN
  logic [NNET*Q*CW-1:0] out_time;
`endif

  modport master (
    input  req, data_in, col_spikes,
    output ack, col_data, col_grst, out_spikes, out_valid, busy
`ifdef MUX_SPIKE_TIME_EN
    , output out_time
`endif
  );

  modport slave (
    output req, data_in, col_spikes,
    input  ack, col_data, col_grst, out_spikes, out_valid, busy
`ifdef MUX_SPIKE_TIME_EN
    , input out_time
`endif
  );

endinterface

// File: rtl/mux_gamma_scheduler_rr_arbiter.sv
// Combinational NNET-wide round-robin arbiter: pointer in, one-hot grant + index out.
// Zero latency; no backpressure, the caller decides when a grant is taken.
module rr_arbiter
  import mux_sched_pkg::*;
#(
  parameter int NNET = NNET_DEF,
  parameter int IW   = (NNET > 1) ? $clog2(NNET) : 1
) (
  input  logic [NNET-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NNET-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            found
);

  logic [RR_MAX-1:0] req_ext;
  logic [RR_IW-1:0]  ptr_ext;
  rr_pick_t          pick;

  always_comb begin
    req_ext           = '0;
    req_ext[NNET-1:0] = req;
    ptr_ext           = '0;
    ptr_ext[IW-1:0]   = ptr;
    pick              = rr_pick(req_ext, ptr_ext, NNET);
    found             = pick.found;
    idx               = IW'(pick.idx);
    grant             = '0;
    if (pick.found) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/mux_gamma_scheduler.sv
// Shares one column between NNET networks, one gamma wave per round-robin grant; ack->out_valid = GAMMA_LEN+2.
// Requests are level-held; no backpressure on results. MUX_SPIKE_TIME_EN adds per-neuron first-spike times.
module mux_gamma_scheduler
  import mux_sched_pkg::*;
#(
  parameter int P         = 64,
  parameter int Q         = 2,
  parameter int NNET      = NNET_DEF,
  parameter int GAMMA_LEN = GAMMA_LEN_DEF,
  parameter int CW        = $clog2(GAMMA_LEN)
) (
  input logic                   clk,
  input logic                   rstb,
  mux_gamma_scheduler_if.master bus
);

  localparam int            IW        = (NNET > 1) ? $clog2(NNET) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(GAMMA_LEN - 1);
  localparam logic [IW-1:0] NET_LAST  = IW'(NNET - 1);

  sched_state_t      state_q, state_d;
  logic [CW-1:0]     tick_q;
  logic [IW-1:0]     rr_q, cur_q, cur_next, arb_ptr, arb_idx;
  logic [NNET-1:0]   arb_grant, ack, out_valid_q;
  logic              arb_found, take, live_q;
  logic [Q-1:0]      capture_q, capture_all;
  logic [NNET*Q-1:0] out_spikes_q;
  logic [P-1:0]      col_data;
  logic              col_grst;

  assign cur_next    = (cur_q == NET_LAST) ? '0 : cur_q + 1'b1;
  // FLUSH arbitrates back-to-back, so it must already see the advanced pointer.
  assign arb_ptr     = (state_q == FLUSH) ? cur_next : rr_q;
  assign capture_all = capture_q | bus.col_spikes;

  rr_arbiter #(
    .NNET (NNET),
    .IW   (IW)
  ) u_arb (
    .req   (bus.req),
    .ptr   (arb_ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .found (arb_found)
  );

  always_comb begin
    state_d  = state_q;
    take     = 1'b0;
    ack      = '0;
    col_grst = 1'b1;
    col_data = '0;
    unique case (state_q)
      IDLE: begin
        if (live_q && arb_found) begin
          take    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        col_grst = 1'b0;
        col_data = bus.data_in[cur_q*P +: P];
        if (tick_q == TICK_LAST) state_d = FLUSH;
      end
      FLUSH: begin
        if (arb_found) begin
          take    = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (take) ack = arb_grant;
  end

  // live_q holds off grants until the first edge after reset release, so no ack
  // is shown to a requester while the FSM is still held in reset.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q      <= IDLE;
      tick_q       <= '0;
      rr_q         <= '0;
      cur_q        <= '0;
      capture_q    <= '0;
      out_spikes_q <= '0;
      out_valid_q  <= '0;
      live_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      live_q      <= 1'b1;
      out_valid_q <= '0;
      if (state_q == RUN) begin
        tick_q    <= tick_q + 1'b1;
        capture_q <= capture_all;
      end
      if (state_q == FLUSH) begin
        out_spikes_q[cur_q*Q +: Q] <= capture_all;
        out_valid_q[cur_q]         <= 1'b1;
        capture_q                  <= '0;
        rr_q                       <= cur_next;
      end
      if (take) begin
        cur_q  <= arb_idx;
        tick_q <= '0;
      end
    end
  end

`ifdef MUX_SPIKE_TIME_EN
  logic [Q*CW-1:0]      first_q;
  logic [Q*CW-1:0]      time_final;
  logic [NNET*Q*CW-1:0] out_time_q;

  always_comb begin
    time_final = '0;
    for (int q = 0; q < Q; q++) begin
      time_final[q*CW +: CW] = capture_q[q] ? first_q[q*CW +: CW] : TICK_LAST;
    end
  end

  // capture_q doubles as the "already fired" flag, so first_q never needs clearing.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      first_q    <= '0;
      out_time_q <= '0;
    end else if (state_q == RUN) begin
      for (int q = 0; q < Q; q++) begin
        if (bus.col_spikes[q] && !capture_q[q]) first_q[q*CW +: CW] <= tick_q;
      end
    end else if (state_q == FLUSH) begin
      out_time_q[cur_q*Q*CW +: Q*CW] <= time_final;
    end
  end

  assign bus.out_time = out_time_q;
`endif

  assign bus.ack        = ack;
  assign bus.col_data   = col_data;
  assign bus.col_grst   = col_grst;
  assign bus.out_spikes = out_spikes_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mux_gamma_scheduler.sv
// Directed bench for mux_gamma_scheduler (P=64, Q=2, NNET=2, GAMMA_LEN=8); inputs change on negedge.
// Build with MUX_SPIKE_TIME_EN to also exercise out_time.
module tb_mux_gamma_scheduler;

  localparam int P         = 64;
  localparam int Q         = 2;
  localparam int NNET      = 2;
  localparam int GAMMA_LEN = 8;
  localparam int CW        = 3;

  logic clk = 1'b0;
  logic rstb;
  int   total = 0;
  int   bad   = 0;

  mux_gamma_scheduler_if #(
    .P    (P),
    .Q    (Q),
    .NNET (NNET)
`ifdef MUX_SPIKE_TIME_EN
    , .CW (CW)
`endif
  ) bus ();

  mux_gamma_scheduler #(
    .P         (P),
    .Q         (Q),
    .NNET      (NNET),
    .GAMMA_LEN (GAMMA_LEN),
    .CW        (CW)
  ) dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  initial begin
    logic [63:0] exp_data;
    logic [1:0]  exp_ack;
    int          vcount;

    rstb           = 1'b0;
    bus.req        = '0;
    bus.data_in    = '0;
    bus.col_spikes = '0;

    // reset values
    repeat (3) @(negedge clk);
    #1;
    check("rst_ack",    64'(bus.ack),        64'(0));
    check("rst_valid",  64'(bus.out_valid),  64'(0));
    check("rst_spikes", 64'(bus.out_spikes), 64'(0));
    check("rst_grst",   64'(bus.col_grst),   64'(1));
    check("rst_busy",   64'(bus.busy),       64'(0));
    @(negedge clk);
    rstb = 1'b1;

    // idle with no requests
    repeat (20) @(negedge clk);
    #1;
    check("idle_busy",  64'(bus.busy),      64'(0));
    check("idle_grst",  64'(bus.col_grst),  64'(1));
    check("idle_data",  64'(bus.col_data),  64'(0));
    check("idle_ack",   64'(bus.ack),       64'(0));
    check("idle_valid", 64'(bus.out_valid), 64'(0));

    // both requesting: alternating grants every 9 cycles, grst high only in FLUSH
    @(negedge clk);
    bus.req = 2'b11;
    #1;
    check("rr_ack0", 64'(bus.ack), 64'(2'b01));
    for (int n = 1; n <= 27; n++) begin
      @(negedge clk);
      #1;
      exp_ack = (n % 9 != 0) ? 2'b00 : (((n / 9) % 2 == 1) ? 2'b10 : 2'b01);
      check("rr_ack",  64'(bus.ack),      64'(exp_ack));
      check("rr_grst", 64'(bus.col_grst), 64'(n % 9 == 0));
    end
    @(negedge clk);
    bus.req = '0;
    repeat (10) @(negedge clk);
    #1;
    check("rr_done_busy", 64'(bus.busy), 64'(0));

    // single net0 wave: input routing, capture and result timing
    @(negedge clk);
    bus.req                     = 2'b01;
    bus.data_in[2*P-1:P]        = '1;
    #1;
    check("s_ack",       64'(bus.ack),      64'(2'b01));
    check("s_idle_data", 64'(bus.col_data), 64'(0));
    for (int t = 0; t < GAMMA_LEN; t++) begin
      @(negedge clk);
      if (t == 0) bus.req = '0;
      bus.data_in[P-1:0] = (t == 3) ? 64'h20 : 64'h0;
      bus.col_spikes     = (t == 4) ? 2'b10 : 2'b00;
      #1;
      exp_data = (t == 3) ? 64'h20 : 64'h0;
      check("s_col_data", bus.col_data,      exp_data);
      check("s_run_grst", 64'(bus.col_grst), 64'(0));
    end
    @(negedge clk);
    bus.data_in[P-1:0] = '1;
    bus.col_spikes     = '0;
    #1;
    check("s_flush_valid", 64'(bus.out_valid), 64'(0));
    check("s_flush_grst",  64'(bus.col_grst),  64'(1));
    check("s_flush_data",  64'(bus.col_data),  64'(0));
    @(negedge clk);
    bus.data_in = '0;
    #1;
    check("s_valid",  64'(bus.out_valid),  64'(2'b01));
    check("s_spikes", 64'(bus.out_spikes), 64'(4'b0010));
    @(negedge clk);
    #1;
    check("s_valid_pulse", 64'(bus.out_valid),  64'(0));
    check("s_spikes_hold", 64'(bus.out_spikes), 64'(4'b0010));

    // both nets in turn (pointer now at net1), no cross-contamination
    @(negedge clk);
    bus.req = 2'b11;
    #1;
    check("x_ack1", 64'(bus.ack), 64'(2'b10));
    for (int t = 0; t < GAMMA_LEN; t++) begin
      @(negedge clk);
      bus.col_spikes = 2'b10;
    end
    @(negedge clk);
    bus.col_spikes = '0;
    #1;
    check("x_ack2", 64'(bus.ack), 64'(2'b01));
    for (int t = 0; t < GAMMA_LEN; t++) begin
      @(negedge clk);
      if (t == 0) begin
        bus.req = '0;
        #1;
        check("x_valid1",  64'(bus.out_valid),  64'(2'b10));
        check("x_spikes1", 64'(bus.out_spikes), 64'(4'b1010));
      end
      bus.col_spikes = 2'b01;
    end
    @(negedge clk);
    bus.col_spikes = '0;
    #1;
    check("x_flush_ack",  64'(bus.ack),      64'(0));
    check("x_flush_grst", 64'(bus.col_grst), 64'(1));
    @(negedge clk);
    #1;
    check("x_valid2",  64'(bus.out_valid),  64'(2'b01));
    check("x_spikes2", 64'(bus.out_spikes), 64'(4'b1001));

    // reset at tick 4 of a wave
    @(negedge clk);
    bus.req        = 2'b01;
    bus.col_spikes = 2'b11;
    #1;
    check("r_ack", 64'(bus.ack), 64'(2'b01));
    for (int t = 0; t <= 4; t++) begin
      @(negedge clk);
      if (t == 0) bus.req = '0;
    end
    rstb = 1'b0;
    #1;
    check("r_busy",   64'(bus.busy),       64'(0));
    check("r_grst",   64'(bus.col_grst),   64'(1));
    check("r_valid",  64'(bus.out_valid),  64'(0));
    check("r_spikes", 64'(bus.out_spikes), 64'(0));
    check("r_ack0",   64'(bus.ack),        64'(0));
    check("r_data",   64'(bus.col_data),   64'(0));
    bus.col_spikes = '0;
    repeat (2) @(negedge clk);
    rstb   = 1'b1;
    vcount = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      #1;
      if (bus.out_valid != 0) vcount++;
    end
    check("r_no_valid", 64'(vcount), 64'(0));
    @(negedge clk);
    bus.req = 2'b11;
    #1;
    check("r_next_ack", 64'(bus.ack), 64'(2'b01));
    @(negedge clk);
    bus.req = '0;
    repeat (10) @(negedge clk);
    #1;
    check("r_after_busy",   64'(bus.busy),       64'(0));
    check("r_after_spikes", 64'(bus.out_spikes), 64'(0));

`ifdef MUX_SPIKE_TIME_EN
    // first-spike times: neuron1 at ticks 2 and 6, neuron0 silent
    @(negedge clk);
    bus.req = 2'b01;
    #1;
    check("t_ack", 64'(bus.ack), 64'(2'b01));
    for (int t = 0; t < GAMMA_LEN; t++) begin
      @(negedge clk);
      if (t == 0) bus.req = '0;
      bus.col_spikes = (t == 2 || t == 6) ? 2'b10 : 2'b00;
    end
    @(negedge clk);
    bus.col_spikes = '0;
    @(negedge clk);
    #1;
    check("t_valid",     64'(bus.out_valid),       64'(2'b01));
    check("t_time_net0", 64'(bus.out_time[5:0]),   64'(6'b010_111));
    check("t_time_net1", 64'(bus.out_time[11:6]),  64'(0));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
